seq_mult: RTL

Parametrised iterative shift-add multiplier, the next generation of the team's fixed 32x32 multiplier.
- Width is generic; adds a per-operation signed/unsigned mode.
- Uses valid/ready handshakes on both the operand side and the result side, so it can sit between pipeline stages that stall.
- One operation in flight; fixed latency of WIDTH iteration cycles.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_abs.sv | 25 ++
 rtl/seq_mult.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier and divider family.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;
  // Widest value twos_neg handles; callers zero-extend and keep the low bits they need.
  localparam int unsigned NEG_MAX_W = 256;

  function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] value);
    return ~value + {{(NEG_MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mult_abs.sv
// Operand conditioner: magnitude and sign of a value, honouring signed/unsigned mode.
module mult_abs
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             is_signed_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  logic [NEG_MAX_W-1:0] neg_full;
  logic                 unused_neg_hi;

  always_comb begin
    neg_full = twos_neg({{(NEG_MAX_W-WIDTH){1'b0}}, value_i});
    sign_o   = is_signed_i & value_i[WIDTH-1];
    // Most-negative value negates to itself, which is the correct unsigned magnitude.
    mag_o    = sign_o ? neg_full[WIDTH-1:0] : value_i;
  end

  assign unused_neg_hi = ^neg_full[NEG_MAX_W-1:WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier with valid/ready handshakes and signed/unsigned mode.
module seq_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH+1)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C,
  output logic               busy
);

  mult_state_t          state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_sign, b_sign;
  logic [WIDTH:0]       upper_sum;
  logic [2*WIDTH:0]     acc_step;
  logic [2*WIDTH-1:0]   prod, prod_neg;
  logic [NEG_MAX_W-1:0] prod_neg_full;
  logic                 unused_prod_hi;

  mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value_i    (A),
    .is_signed_i(is_signed),
    .mag_o      (a_mag),
    .sign_o     (a_sign)
  );

  mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value_i    (B),
    .is_signed_i(is_signed),
    .mag_o      (b_mag),
    .sign_o     (b_sign)
  );

  // Accumulator layout: {carry, partial product high half, remaining multiplier bits}.
  always_comb begin
    upper_sum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step      = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
    prod          = acc_step[2*WIDTH-1:0];
    prod_neg_full = twos_neg({{(NEG_MAX_W-2*WIDTH){1'b0}}, prod});
    prod_neg      = prod_neg_full[2*WIDTH-1:0];
  end

  assign unused_prod_hi = ^prod_neg_full[NEG_MAX_W-1:2*WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a_mag;
          acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
          neg_d   = a_sign ^ b_sign;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          c_d     = neg_q ? prod_neg : prod;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C         = c_q;

`ifndef SYNTHESIS
  a_valid_in_done: assert property (@(posedge CLK) disable iff (rst)
    out_valid |-> state_q == DONE);
  a_c_stable: assert property (@(posedge CLK) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(C));
`endif

endmodule
